// File: rtl/traffic_light_pkg.sv
// Shared types and lamp encodings for the two-road traffic light controller.
package traffic_light_pkg;

  typedef enum logic [2:0] {G1, Y1, AR1, G2, Y2, AR2, NIGHT} state_e;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Returns {light1, light2} for a state; flash only matters in NIGHT.
  function automatic logic [5:0] state_lamps(state_e s, logic flash);
    logic [5:0] lamps;
    case (s)
      G1:      lamps = {LAMP_G, LAMP_R};
      Y1:      lamps = {LAMP_Y, LAMP_R};
      G2:      lamps = {LAMP_R, LAMP_G};
      Y2:      lamps = {LAMP_R, LAMP_Y};
      NIGHT:   lamps = flash ? {LAMP_Y, LAMP_Y} : {LAMP_OFF, LAMP_OFF};
      default: lamps = {LAMP_R, LAMP_R};
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Road-side signal bundle: mode/button inputs, lamp drives and countdown display.
interface traffic_light_ctrl_if;
  logic       night_mode;
  logic       ped_req;
  logic [2:0] light1;
  logic [2:0] light2;
  logic [3:0] cnt_tens;
  logic [3:0] cnt_ones;
  logic       cnt_blank;
  logic       tick;

  modport master (
    output night_mode, ped_req,
    input  light1, light2, cnt_tens, cnt_ones, cnt_blank, tick
  );

  modport slave (
    input  night_mode, ped_req,
    output light1, light2, cnt_tens, cnt_ones, cnt_blank, tick
  );
endinterface

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle tick pulse at TICK_HZ.
module tick_prescaler #(
  parameter int unsigned CLK_HZ  = 30_000_000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic clk30M,
  input  logic Reset,
  output logic tick
);

  localparam int unsigned Div  = CLK_HZ / TICK_HZ;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

  logic [CntW-1:0] r_cnt;
  logic            w_wrap;

  assign w_wrap = (r_cnt == CntW'(Div - 1));
  assign tick   = w_wrap;

  always_ff @(posedge clk30M or negedge Reset) begin
    if (!Reset) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller: phase FSM with all-red clearance, pedestrian
// shortening of green, flashing-yellow night mode and a BCD countdown output.
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 30_000_000,
  parameter int unsigned TICK_HZ  = 1,
  parameter int unsigned T_GREEN1 = 40,
  parameter int unsigned T_GREEN2 = 25,
  parameter int unsigned T_YELLOW = 5,
  parameter int unsigned T_ALLRED = 2,
  parameter int unsigned T_PED    = 5,
  parameter int unsigned CNT_W    = 7
) (
  input  logic                 clk30M,
  input  logic                 Reset,
  traffic_light_ctrl_if.slave  bus
);

  if (T_GREEN1 < 1 || T_GREEN1 > 99 || T_GREEN2 < 1 || T_GREEN2 > 99 ||
      T_YELLOW < 1 || T_YELLOW > 99 || T_ALLRED < 1 || T_ALLRED > 99 ||
      T_PED < 1 || T_PED > 99) begin : g_bad_duration
    $error("traffic_light_ctrl: phase durations must lie in 1..99");
  end
  if (TICK_HZ == 0 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_tick
    $error("traffic_light_ctrl: CLK_HZ must be a multiple of TICK_HZ");
  end
  if (CNT_W < 7) begin : g_bad_width
    $error("traffic_light_ctrl: CNT_W too narrow to hold 99");
  end

  localparam logic [CNT_W-1:0] RemGreen1 = CNT_W'(T_GREEN1);
  localparam logic [CNT_W-1:0] RemGreen2 = CNT_W'(T_GREEN2);
  localparam logic [CNT_W-1:0] RemYellow = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] RemAllRed = CNT_W'(T_ALLRED);
  localparam logic [CNT_W-1:0] RemPed    = CNT_W'(T_PED);
  localparam logic [CNT_W-1:0] RemOne    = CNT_W'(1);
  localparam logic [CNT_W-1:0] RemTen    = CNT_W'(10);

  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_rem, w_rem_next;
  logic             r_ped_pend, w_ped_next;
  logic             r_flash, w_flash_next;
  logic [2:0]       r_light1, r_light2;
  logic             w_tick;
  logic             w_enter_y;

  tick_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_prescaler (
    .clk30M (clk30M),
    .Reset  (Reset),
    .tick   (w_tick)
  );

  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_rem;
    w_flash_next = r_flash;
    w_enter_y    = 1'b0;
    if (w_tick) begin
      case (r_state)
        G1, G2: begin
          // Night request cuts green short; otherwise a pending pedestrian trims it.
          if (bus.night_mode || r_rem == RemOne) begin
            w_state_next = (r_state == G1) ? Y1 : Y2;
            w_rem_next   = RemYellow;
            w_enter_y    = 1'b1;
          end else if (r_ped_pend && r_rem > RemPed) begin
            w_rem_next = RemPed;
          end else begin
            w_rem_next = r_rem - 1'b1;
          end
        end
        Y1, Y2: begin
          if (r_rem == RemOne) begin
            w_state_next = (r_state == Y1) ? AR2 : AR1;
            w_rem_next   = RemAllRed;
          end else begin
            w_rem_next = r_rem - 1'b1;
          end
        end
        AR1, AR2: begin
          if (r_rem == RemOne) begin
            if (bus.night_mode) begin
              w_state_next = NIGHT;
              w_rem_next   = '0;
            end else if (r_state == AR1) begin
              w_state_next = G1;
              w_rem_next   = RemGreen1;
            end else begin
              w_state_next = G2;
              w_rem_next   = RemGreen2;
            end
          end else begin
            w_rem_next = r_rem - 1'b1;
          end
        end
        NIGHT: begin
          if (!bus.night_mode) begin
            w_state_next = AR1;
            w_rem_next   = RemAllRed;
            w_flash_next = 1'b0;
          end else begin
            w_flash_next = ~r_flash;
          end
        end
        default: begin
          w_state_next = AR1;
          w_rem_next   = RemAllRed;
        end
      endcase
    end
    w_ped_next = bus.ped_req | (r_ped_pend & ~w_enter_y);
  end

  always_ff @(posedge clk30M or negedge Reset) begin
    if (!Reset) begin
      r_state    <= AR1;
      r_rem      <= RemAllRed;
      r_ped_pend <= 1'b0;
      r_flash    <= 1'b0;
      r_light1   <= LAMP_R;
      r_light2   <= LAMP_R;
    end else begin
      r_state              <= w_state_next;
      r_rem                <= w_rem_next;
      r_ped_pend           <= w_ped_next;
      r_flash              <= w_flash_next;
      {r_light1, r_light2} <= state_lamps(r_state, r_flash);
    end
  end

  assign bus.light1    = r_light1;
  assign bus.light2    = r_light2;
  assign bus.cnt_tens  = 4'(r_rem / RemTen);
  assign bus.cnt_ones  = 4'(r_rem % RemTen);
  assign bus.cnt_blank = (r_state == NIGHT);
  assign bus.tick      = w_tick;

endmodule
